hazard3_instr_align_buf: RTL and testbench

Halfword-granular instruction alignment buffer. It sits between the fetch bus interface and the instruction decompressor. It accepts 32-bit naturally aligned fetch words and presents a 32-bit window starting at the current instruction halfword, so 16-bit and 32-bit instructions can be consumed at any halfword alignment. Flushes on jumps/traps discard buffered data and drop the lower halfword of the first word when the target is halfword-aligned.

---
 rtl/hazard3_instr_align_buf.sv | 108 ++++++++++
 tb/tb_hazard3_instr_align_buf.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_instr_align_buf.sv
// Halfword-granular instruction alignment buffer: turns aligned 32-bit fetch words into a
// 32-bit window starting at the current instruction halfword.
module hazard3_instr_align_buf #(
    parameter int unsigned EXTENSION_C = 1,
    parameter int unsigned DEPTH_HW    = 6,
    localparam int unsigned W_LEVEL    = $clog2(DEPTH_HW + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_fetch_vld,
    output logic               o_fetch_rdy,
    input  logic [31:0]        i_fetch_data,
    input  logic               i_fetch_err,
    input  logic               i_flush,
    input  logic               i_flush_addr_hw,
    output logic [31:0]        o_cir,
    output logic [1:0]         o_cir_vld,
    output logic [1:0]         o_cir_err,
    input  logic [1:0]         i_cir_use,
    output logic [W_LEVEL-1:0] o_level
);

    logic [15:0]         r_data [DEPTH_HW];
    logic [DEPTH_HW-1:0] r_err;
    logic [W_LEVEL-1:0]  r_count;
    logic                r_skip_hw;

    logic [15:0]         w_data_d [DEPTH_HW];
    logic [DEPTH_HW-1:0] w_err_d;
    logic [W_LEVEL-1:0]  w_count_d;
    logic                w_skip_hw_d;
    logic [1:0]          w_cir_vld;
    logic [1:0]          w_use_eff;
    logic [1:0]          w_fill;
    logic                w_accept;
    logic [W_LEVEL-1:0]  w_base;

    assign w_cir_vld   = (r_count >= W_LEVEL'(2)) ? 2'd2 : r_count[1:0];
    assign w_use_eff   = (i_cir_use > w_cir_vld) ? w_cir_vld : i_cir_use;
    // Ready depends on registered count only, so a stalled consumer can never overflow us.
    assign o_fetch_rdy = (r_count <= W_LEVEL'(DEPTH_HW - 2));
    assign w_accept    = i_fetch_vld & o_fetch_rdy & ~i_flush;
    assign w_fill      = w_accept ? (r_skip_hw ? 2'd1 : 2'd2) : 2'd0;
    assign w_base      = r_count - W_LEVEL'(w_use_eff);
    assign w_count_d   = i_flush ? '0 : (w_base + W_LEVEL'(w_fill));
    assign w_skip_hw_d = i_flush ? (i_flush_addr_hw && (EXTENSION_C != 0))
                                 : (w_accept ? 1'b0 : r_skip_hw);

    always_comb begin
        w_data_d = r_data;
        w_err_d  = r_err;
        if (!i_flush) begin
            if (w_use_eff == 2'd1) begin
                for (int i = 0; i < int'(DEPTH_HW) - 1; i++) begin
                    w_data_d[i] = r_data[i + 1];
                    w_err_d[i]  = r_err[i + 1];
                end
            end else if (w_use_eff == 2'd2) begin
                for (int i = 0; i < int'(DEPTH_HW) - 2; i++) begin
                    w_data_d[i] = r_data[i + 2];
                    w_err_d[i]  = r_err[i + 2];
                end
            end
            // New halfwords land just above the survivors of this cycle's consume.
            if (w_accept) begin
                for (int i = 0; i < int'(DEPTH_HW); i++) begin
                    if (W_LEVEL'(i) == w_base) begin
                        w_data_d[i] = r_skip_hw ? i_fetch_data[31:16] : i_fetch_data[15:0];
                        w_err_d[i]  = i_fetch_err;
                    end else if (!r_skip_hw && (W_LEVEL'(i) == w_base + W_LEVEL'(1))) begin
                        w_data_d[i] = i_fetch_data[31:16];
                        w_err_d[i]  = i_fetch_err;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH_HW); i++) begin
                r_data[i] <= '0;
            end
            r_err     <= '0;
            r_count   <= '0;
            r_skip_hw <= 1'b0;
        end else begin
            r_data    <= w_data_d;
            r_err     <= w_err_d;
            r_count   <= w_count_d;
            r_skip_hw <= w_skip_hw_d;
        end
    end

    assign o_cir     = {r_data[1], r_data[0]};
    assign o_cir_vld = w_cir_vld;
    assign o_cir_err = {r_err[1] & (r_count >= W_LEVEL'(2)), r_err[0] & (r_count != '0)};
    assign o_level   = r_count;

    a_use_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        i_flush || (i_cir_use <= w_cir_vld))
        else $error("cir_use exceeds valid halfwords");

    a_no_half_use: assert property (@(posedge clk) disable iff (!rst_n)
        (EXTENSION_C != 0) || i_flush || (i_cir_use != 2'd1))
        else $error("cir_use of 1 without compressed support");

endmodule

// File: tb/tb_hazard3_instr_align_buf.sv
// Scoreboard bench for hazard3_instr_align_buf: stimulus queues expected output snapshots tagged
// with a cycle number, a monitor pops and compares them on the falling edge.
module tb_hazard3_instr_align_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_vld;
    logic        fetch_rdy;
    logic [31:0] fetch_data;
    logic        fetch_err;
    logic        flush;
    logic        flush_addr_hw;
    logic [31:0] cir;
    logic [1:0]  cir_vld;
    logic [1:0]  cir_err;
    logic [1:0]  cir_use;
    logic [2:0]  level;

    hazard3_instr_align_buf #(
        .EXTENSION_C (1),
        .DEPTH_HW    (6)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_fetch_vld     (fetch_vld),
        .o_fetch_rdy     (fetch_rdy),
        .i_fetch_data    (fetch_data),
        .i_fetch_err     (fetch_err),
        .i_flush         (flush),
        .i_flush_addr_hw (flush_addr_hw),
        .o_cir           (cir),
        .o_cir_vld       (cir_vld),
        .o_cir_err       (cir_err),
        .i_cir_use       (cir_use),
        .o_level         (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] cir;
        logic [31:0] mask;
        logic [1:0]  vld;
        logic [1:0]  err;
        logic [2:0]  level;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_now(input string nm, input logic [31:0] c, input logic [31:0] m,
                              input logic [1:0] v, input logic [1:0] e, input logic [2:0] l,
                              input logic r);
        exp_t x;
        x.cyc = cyc; x.name = nm; x.cir = c; x.mask = m;
        x.vld = v; x.err = e; x.level = l; x.rdy = r;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every snapshot due this cycle, flags any that were skipped.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                exp_t x;
                x = exp_q.pop_front();
                n_checks++;
                if (x.cyc != cyc) begin
                    $display("FAIL %s: snapshot for cycle %0d observed at cycle %0d",
                             x.name, x.cyc, cyc);
                end else if (((cir & x.mask) !== (x.cir & x.mask)) || cir_vld !== x.vld ||
                             cir_err !== x.err || level !== x.level || fetch_rdy !== x.rdy) begin
                    $display("FAIL %s: got cir=%08h vld=%0d err=%b level=%0d rdy=%b, want cir=%08h/%08h vld=%0d err=%b level=%0d rdy=%b",
                             x.name, cir, cir_vld, cir_err, level, fetch_rdy,
                             x.cir, x.mask, x.vld, x.err, x.level, x.rdy);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    localparam logic [31:0] MALL = 32'hffff_ffff;
    localparam logic [31:0] MLO  = 32'h0000_ffff;
    localparam logic [31:0] MNONE = 32'h0;

    task automatic push(input logic [31:0] d, input logic e, input logic [1:0] u);
        fetch_vld = 1'b1; fetch_data = d; fetch_err = e; cir_use = u;
        tick();
    endtask

    task automatic idle(input logic [1:0] u);
        fetch_vld = 1'b0; fetch_err = 1'b0; cir_use = u;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; fetch_vld = 1'b0; fetch_data = '0; fetch_err = 1'b0;
        flush = 1'b0; flush_addr_hw = 1'b0; cir_use = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        expect_now("reset", 32'h0, MALL, 2'd0, 2'b00, 3'd0, 1'b1);

        // Fill to capacity with no consumption.
        push(32'h0001_1111, 1'b0, 2'd0);
        expect_now("fill1", 32'h0001_1111, MALL, 2'd2, 2'b00, 3'd2, 1'b1);
        push(32'h0002_2222, 1'b0, 2'd0);
        expect_now("fill2", 32'h0001_1111, MALL, 2'd2, 2'b00, 3'd4, 1'b1);
        push(32'h0003_3333, 1'b0, 2'd0);
        expect_now("fill3_full", 32'h0001_1111, MALL, 2'd2, 2'b00, 3'd6, 1'b0);
        push(32'h0009_9999, 1'b0, 2'd0);
        expect_now("full_hold", 32'h0001_1111, MALL, 2'd2, 2'b00, 3'd6, 1'b0);
        idle(2'd2);
        expect_now("drain1", 32'h0002_2222, MALL, 2'd2, 2'b00, 3'd4, 1'b1);
        idle(2'd2);
        expect_now("drain2", 32'h0003_3333, MALL, 2'd2, 2'b00, 3'd2, 1'b1);
        idle(2'd2);
        expect_now("drain_empty", 32'h0, MNONE, 2'd0, 2'b00, 3'd0, 1'b1);

        // Mixed 16/32-bit consumption.
        push(32'h0002_4501, 1'b0, 2'd0);
        expect_now("mix_w0", 32'h0002_4501, MALL, 2'd2, 2'b00, 3'd2, 1'b1);
        push(32'hABCD_1234, 1'b0, 2'd0);
        expect_now("mix_w1", 32'h0002_4501, MALL, 2'd2, 2'b00, 3'd4, 1'b1);
        idle(2'd1);
        expect_now("mix_use1", 32'h1234_0002, MALL, 2'd2, 2'b00, 3'd3, 1'b1);
        idle(2'd2);
        expect_now("mix_use2", 32'h0000_ABCD, MLO, 2'd1, 2'b00, 3'd1, 1'b1);
        idle(2'd1);
        expect_now("mix_empty", 32'h0, MNONE, 2'd0, 2'b00, 3'd0, 1'b1);

        // Halfword-aligned flush target, then the count=DEPTH_HW-1 boundary.
        flush = 1'b1; flush_addr_hw = 1'b1;
        idle(2'd0);
        flush = 1'b0; flush_addr_hw = 1'b0;
        expect_now("flush_hw", 32'h0, MNONE, 2'd0, 2'b00, 3'd0, 1'b1);
        push(32'h8000_8082, 1'b0, 2'd0);
        expect_now("skip_first", 32'h0000_8000, MLO, 2'd1, 2'b00, 3'd1, 1'b1);
        push(32'h1111_2222, 1'b0, 2'd0);
        expect_now("after_skip", 32'h2222_8000, MALL, 2'd2, 2'b00, 3'd3, 1'b1);
        push(32'h4444_3333, 1'b0, 2'd0);
        expect_now("level5", 32'h2222_8000, MALL, 2'd2, 2'b00, 3'd5, 1'b0);
        push(32'h6666_5555, 1'b0, 2'd2);
        expect_now("l5_no_fill", 32'h3333_1111, MALL, 2'd2, 2'b00, 3'd3, 1'b1);
        push(32'h6666_5555, 1'b0, 2'd0);
        expect_now("l3_fill", 32'h3333_1111, MALL, 2'd2, 2'b00, 3'd5, 1'b0);
        idle(2'd2);
        expect_now("l5_drain", 32'h5555_4444, MALL, 2'd2, 2'b00, 3'd3, 1'b1);
        idle(2'd2);
        expect_now("l3_drain", 32'h0000_6666, MLO, 2'd1, 2'b00, 3'd1, 1'b1);
        idle(2'd1);
        expect_now("l1_drain", 32'h0, MNONE, 2'd0, 2'b00, 3'd0, 1'b1);

        // Flush racing a fetch handshake.
        push(32'h1212_1212, 1'b0, 2'd0);
        expect_now("pre_flush", 32'h1212_1212, MALL, 2'd2, 2'b00, 3'd2, 1'b1);
        flush = 1'b1;
        push(32'h7777_7777, 1'b0, 2'd2);
        flush = 1'b0;
        expect_now("flush_hs", 32'h0, MNONE, 2'd0, 2'b00, 3'd0, 1'b1);
        idle(2'd0);
        expect_now("flush_discard", 32'h0, MNONE, 2'd0, 2'b00, 3'd0, 1'b1);
        push(32'h9999_AAAA, 1'b0, 2'd0);
        expect_now("post_flush", 32'h9999_AAAA, MALL, 2'd2, 2'b00, 3'd2, 1'b1);
        idle(2'd2);
        expect_now("post_flush_e", 32'h0, MNONE, 2'd0, 2'b00, 3'd0, 1'b1);

        // Bus errors, with and without a skipped halfword.
        flush = 1'b1; flush_addr_hw = 1'b1;
        idle(2'd0);
        flush = 1'b0; flush_addr_hw = 1'b0;
        push(32'hDEAD_BEEF, 1'b1, 2'd0);
        expect_now("err_skip", 32'h0000_DEAD, MLO, 2'd1, 2'b01, 3'd1, 1'b1);
        push(32'h5555_AAAA, 1'b0, 2'd0);
        expect_now("err_mixed", 32'hAAAA_DEAD, MALL, 2'd2, 2'b01, 3'd3, 1'b1);
        idle(2'd1);
        expect_now("err_gone", 32'h5555_AAAA, MALL, 2'd2, 2'b00, 3'd2, 1'b1);
        idle(2'd2);
        push(32'hCAFE_0001, 1'b1, 2'd0);
        expect_now("err_full", 32'hCAFE_0001, MALL, 2'd2, 2'b11, 3'd2, 1'b1);
        idle(2'd2);
        expect_now("err_empty", 32'h0, MNONE, 2'd0, 2'b00, 3'd0, 1'b1);

        // Streaming: one word in, one word out per cycle.
        push({16'd1, 16'd0}, 1'b0, 2'd0);
        for (int k = 1; k <= 20; k++) begin
            push({16'(2 * k + 1), 16'(2 * k)}, 1'b0, 2'd2);
            expect_now($sformatf("stream%0d", k), {16'(2 * k + 1), 16'(2 * k)}, MALL,
                       2'd2, 2'b00, 3'd2, 1'b1);
        end
        idle(2'd0);

        // Asynchronous reset mid-stream.
        rst_n = 1'b0;
        expect_now("async_rst", 32'h0, MALL, 2'd0, 2'b00, 3'd0, 1'b1);
        tick();
        rst_n = 1'b1;
        idle(2'd0);
        expect_now("after_rst", 32'h0, MALL, 2'd0, 2'b00, 3'd0, 1'b1);

        repeat (3) tick();
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL leftover: %0d snapshots never compared, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
